// File: rtl/regfile_checkpoint_ctrl.sv
// Checkpoint/rollback engine for the integer register file: saves x1..x31 into a
// shadow store with an XOR signature, and verifies then restores them on request.
module regfile_checkpoint_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_req,
    input  logic              restore_req,
    output logic [AW-1:0]     rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [AW-1:0]     rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              ckpt_valid
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        VERIFY,
        WRITE,
        FINISH,
        FAIL
    } state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] sig;
    logic [DATA_W-1:0] check;
    logic [DATA_W-1:0] shadow [NUM_REGS];

    logic [AW-1:0]     idx_next;
    logic [DATA_W-1:0] check_final;
    logic              last;

    assign idx_next    = idx + FIRST_IDX;
    assign check_final = check ^ shadow[idx];
    assign last        = (idx == LAST_IDX);

    // Shadow store is deliberately left unreset; only a completed save makes it valid.
    always_ff @(posedge clk) begin
        if (state == SAVE) begin
            shadow[idx] <= rf_read_data;
        end
    end

    // Control FSM; every port value is set one edge ahead so outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            sig             <= '0;
            check           <= '0;
            rf_read_addr    <= '0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            rf_write_enable <= 1'b0;
            stall           <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            ckpt_valid      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (save_req) begin
                        state        <= SAVE;
                        idx          <= FIRST_IDX;
                        sig          <= '0;
                        ckpt_valid   <= 1'b0;
                        stall        <= 1'b1;
                        rf_read_addr <= FIRST_IDX;
                    end else if (restore_req && ckpt_valid) begin
                        state <= VERIFY;
                        idx   <= FIRST_IDX;
                        check <= '0;
                        stall <= 1'b1;
                    end else if (restore_req) begin
                        state <= FAIL;
                        err   <= 1'b1;
                    end
                end

                SAVE: begin
                    sig <= sig ^ rf_read_data;
                    if (last) begin
                        state        <= FINISH;
                        ckpt_valid   <= 1'b1;
                        stall        <= 1'b0;
                        done         <= 1'b1;
                        rf_read_addr <= '0;
                    end else begin
                        idx          <= idx_next;
                        rf_read_addr <= idx_next;
                    end
                end

                VERIFY: begin
                    check <= check_final;
                    if (last) begin
                        if (check_final == sig) begin
                            state           <= WRITE;
                            idx             <= FIRST_IDX;
                            rf_write_enable <= 1'b1;
                            rf_write_addr   <= FIRST_IDX;
                            rf_write_data   <= shadow[FIRST_IDX];
                        end else begin
                            state      <= FAIL;
                            ckpt_valid <= 1'b0;
                            stall      <= 1'b0;
                            err        <= 1'b1;
                        end
                    end else begin
                        idx <= idx_next;
                    end
                end

                WRITE: begin
                    if (last) begin
                        state           <= FINISH;
                        rf_write_enable <= 1'b0;
                        rf_write_addr   <= '0;
                        rf_write_data   <= '0;
                        stall           <= 1'b0;
                        done            <= 1'b1;
                    end else begin
                        idx           <= idx_next;
                        rf_write_addr <= idx_next;
                        rf_write_data <= shadow[idx_next];
                    end
                end

                FINISH: state <= IDLE;

                FAIL: state <= IDLE;

                default: begin
                    state           <= IDLE;
                    stall           <= 1'b0;
                    rf_write_enable <= 1'b0;
                    rf_write_addr   <= '0;
                    rf_write_data   <= '0;
                    rf_read_addr    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_checkpoint_ctrl.md
# regfile_checkpoint_ctrl

Checkpoint/rollback engine for the protected RISC-V core's integer register file. On request it drives the register file's read port to copy registers x1–x31 into a private shadow store with an XOR signature. On a later request it verifies the shadow store against that signature and drives the register file's write port to restore x1–x31. It sits beside the register file, muxed onto its read-port-1 and write-port inputs while `stall` is high, and is the recovery half of the fault-protection scheme.

## Interface
- `NUM_REGS`, 32: register count; x0 is never saved or written.
- `DATA_W`, 32: register width.
- `AW`, $clog2(NUM_REGS): register address width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `save_req`  in  1  single-cycle request to take a checkpoint.
- `restore_req`  in  1  single-cycle request to roll back to the checkpoint.
- `rf_read_addr`  out  AW  address to register-file read port.
- `rf_read_data`  in  DATA_W  combinational read data for `rf_read_addr`.
- `rf_write_addr`  out  AW  address to register-file write port.
- `rf_write_data`  out  DATA_W  write data.
- `rf_write_enable`  out  1  write strobe.
- `stall`  out  1  core must freeze and yield both ports; high in SAVE, VERIFY, WRITE.
- `done`  out  1  one-cycle pulse when save or restore completes successfully.
- `err`  out  1  one-cycle pulse when a restore is refused.
- `ckpt_valid`  out  1  a complete, unverified-corrupt checkpoint is held.

## Operation
- FSM states: IDLE, SAVE, VERIFY, WRITE, FINISH, FAIL.
- Index counter `idx` (AW bits) runs 1..NUM_REGS-1.
- Signature `sig` (DATA_W bits) is the XOR of all saved words.
- IDLE:
  - All rf outputs are 0. `rf_write_enable` = 0.
  - If `save_req`, set `idx`=1, clear `sig`, clear `ckpt_valid`, and go to SAVE. `save_req` wins if both requests arrive together.
  - Else if `restore_req` and `ckpt_valid`, set `idx`=1, clear the running check value, and go to VERIFY.
  - Else if `restore_req` and not `ckpt_valid`, go to FAIL.
- SAVE:
  - Each cycle: `rf_read_addr`=`idx`.
  - At the clock edge: `shadow[idx]` ← `rf_read_data` and `sig` ^= `rf_read_data`.
  - After `idx`=NUM_REGS-1, go to FINISH and set `ckpt_valid`.
- VERIFY:
  - Each cycle, XOR `shadow[idx]` into the check value. No register-file access.
  - After the last index, compare the check value with `sig`.
  - Equal: set `idx`=1 and go to WRITE.
  - Not equal: clear `ckpt_valid` and go to FAIL.
- WRITE:
  - Each cycle: `rf_write_enable`=1, `rf_write_addr`=`idx`, `rf_write_data`=`shadow[idx]`.
  - After the last index, go to FINISH. `ckpt_valid` stays set, so the same checkpoint can be restored repeatedly.
- FINISH: `done`=1 for one cycle, then IDLE.
- FAIL: `err`=1 for one cycle, then IDLE. No register-file writes ever occur on a failed restore.
- Requests that arrive outside IDLE are ignored and not queued.
- Address 0 is never driven with `rf_write_enable`=1.

## Timing
- Reset values:
  - State is IDLE.
  - `stall`, `done`, `err`, `ckpt_valid`, `rf_write_enable` = 0.
  - `rf_read_addr`, `rf_write_addr`, `rf_write_data` = 0.
  - `sig` = 0.
  - Shadow store is not reset.
- `save_req` sampled high at edge T:
  - SAVE occupies cycles T+1..T+31 (addresses 1..31), with `stall` high.
  - `done` is high in cycle T+32, with `stall` low. `ckpt_valid` is high from T+32.
- Valid restore sampled at edge T:
  - VERIFY occupies T+1..T+31.
  - WRITE occupies T+32..T+62; registers are updated at the edges ending each of those cycles.
  - `done` is high at T+63. `stall` is high T+1..T+62.
- Restore without a checkpoint: `err` is high at T+1; `stall` never rises.
- Signature mismatch: `err` is high at T+32; no write strobes are issued.
- All outputs are registered or decoded from state and `idx` only. There is no combinational path from `save_req`/`restore_req` to outputs.
- Asserting `rst` mid-operation:
  - Returns to IDLE immediately and clears `ckpt_valid`.
  - A partial WRITE leaves the register file partially restored; this is accepted.
- Counter never wraps: the terminal compare uses `idx`==NUM_REGS-1.

## Test plan
- Preload x1..x31 = 0x1000+i. Pulse `save_req`. Expect exactly 31 `stall` cycles, read addresses 1..31 in order, `done` at T+32, and `ckpt_valid`=1.
- Take the save above, overwrite all registers with 0xDEADBEEF, then pulse `restore_req`. Expect 62 `stall` cycles, 31 writes with addresses 1..31 and data 0x1000+i, `done` at T+63, and register-file contents restored.
- From reset, pulse `restore_req`. Expect `err` at T+1, zero `rf_write_enable` cycles, and `stall` never high.
- Take a save, force-flip bit 0 of `shadow[7]`, then restore. Expect `err` at T+32, zero write strobes, `ckpt_valid`=0, and register file unchanged.
- Assert `save_req` and `restore_req` together in IDLE, expecting SAVE. Then pulse both requests during SAVE and expect them to be ignored, with the save still completing in 31 cycles.
- Assert `rst` at WRITE cycle 10. Expect outputs at reset values in the same cycle and `ckpt_valid`=0; a subsequent restore gives `err`.
